// File: rtl/traffic_pkg.sv
// Shared encodings and helpers for the traffic display slice: sequencer state codes,
// lamp patterns, the 7-segment table and the BCD conversion helpers.
package traffic_pkg;

    localparam logic [2:0] ST_GR = 3'd3;
    localparam logic [2:0] ST_YR = 3'd4;
    localparam logic [2:0] ST_RG = 3'd5;
    localparam logic [2:0] ST_RY = 3'd6;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam logic [6:0] TIME_SAT    = 7'd99;
    localparam logic [2:0] SHIFT_STEPS = 3'd7;

    // Segments {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {ConvIdle, ConvLoad, ConvShift, ConvDone} conv_state_e;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd2_t;

    function automatic logic [6:0] sat_time(input logic [6:0] t);
        return (t > TIME_SAT) ? TIME_SAT : t;
    endfunction

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        return (nib > 4'd9) ? 7'h00 : SEG_TABLE[nib];
    endfunction

    function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/traffic_display_if.sv
// Sequencer-side inputs and lamp/display outputs of the traffic display block.
interface traffic_display_if;
    logic       enable;
    logic [2:0] state;
    logic [6:0] timeLane1;
    logic [6:0] timeLane2;
    logic [2:0] lamp1;
    logic [2:0] lamp2;
    logic [6:0] seg;
    logic [3:0] an;

    modport master (
        output enable, state, timeLane1, timeLane2,
        input  lamp1, lamp2, seg, an
    );

    modport slave (
        input  enable, state, timeLane1, timeLane2,
        output lamp1, lamp2, seg, an
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: snapshots a 7-bit count (saturated to 99) on start_i and
// produces two BCD digits after seven shift cycles; done_o marks the result cycle.
module bin2bcd_seq
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       start_i,
    input  logic [6:0] bin_i,
    output bcd2_t      bcd_o,
    output logic       last_o,
    output logic       done_o
);

    logic [6:0] work_q, work_d;
    bcd2_t      bcd_q, bcd_d;
    bcd2_t      adj;
    logic [2:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;

    always_comb begin
        work_d    = work_q;
        bcd_d     = bcd_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        adj.tens  = dabble_adj(bcd_q.tens);
        adj.units = dabble_adj(bcd_q.units);
        if (clear_i) begin
            work_d = '0;
            bcd_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b0;
        end else if (start_i) begin
            work_d = sat_time(bin_i);
            bcd_d  = '0;
            cnt_d  = SHIFT_STEPS;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q != 3'd0) begin
                {bcd_d, work_d} = {adj, work_q} << 1;
                cnt_d           = cnt_q - 3'd1;
            end else begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work_q <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            work_q <= work_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign bcd_o  = bcd_q;
    assign last_o = busy_q && (cnt_q == 3'd1);
    assign done_o = busy_q && (cnt_q == 3'd0);

endmodule

// File: rtl/traffic_display.sv
// Lamp decoder, BCD conversion control and 4-digit multiplexed 7-segment driver
// for the two-lane traffic sequencer.
module traffic_display
    import traffic_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input logic              clk,
    input logic              reset,
    traffic_display_if.slave bus
);

    localparam logic [19:0] SCAN_LAST = 20'(SCAN_DIV - 1);

    conv_state_e conv_q, conv_d;
    logic        conv_start, conv_clear, publish;
    logic        last1, last2, done1, done2;
    bcd2_t       bcd1, bcd2;
    bcd2_t       disp1_q, disp1_d, disp2_q, disp2_d;
    logic [19:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]  digit_q, digit_d;
    logic [2:0]  lamp1_q, lamp1_d, lamp2_q, lamp2_d;
    logic [3:0]  an_q, an_d, an_sel;
    logic [6:0]  seg_q, seg_d;
    logic [3:0]  nib;
    logic        tens_sel;

    assign conv_clear = !bus.enable;

    bin2bcd_seq u_lane1 (
        .clk     (clk),
        .reset   (reset),
        .clear_i (conv_clear),
        .start_i (conv_start),
        .bin_i   (bus.timeLane1),
        .bcd_o   (bcd1),
        .last_o  (last1),
        .done_o  (done1)
    );

    bin2bcd_seq u_lane2 (
        .clk     (clk),
        .reset   (reset),
        .clear_i (conv_clear),
        .start_i (conv_start),
        .bin_i   (bus.timeLane2),
        .bcd_o   (bcd2),
        .last_o  (last2),
        .done_o  (done2)
    );

    always_comb begin
        conv_d     = conv_q;
        conv_start = 1'b0;
        publish    = 1'b0;
        if (!bus.enable) begin
            conv_d = ConvIdle;
        end else begin
            unique case (conv_q)
                ConvIdle:  conv_d = ConvLoad;
                ConvLoad: begin
                    conv_start = 1'b1;
                    conv_d     = ConvShift;
                end
                ConvShift: if (last1 && last2) conv_d = ConvDone;
                ConvDone: begin
                    publish = done1 && done2;
                    conv_d  = ConvLoad;
                end
                default:   conv_d = ConvIdle;
            endcase
        end
    end

    // Both lanes land together so the four digits never show a mixed refresh.
    always_comb begin
        disp1_d = disp1_q;
        disp2_d = disp2_q;
        if (!bus.enable) begin
            disp1_d = '0;
            disp2_d = '0;
        end else if (publish) begin
            disp1_d = bcd1;
            disp2_d = bcd2;
        end
    end

    always_comb begin
        lamp1_d = LAMP_RED;
        lamp2_d = LAMP_RED;
        if (bus.enable) begin
            case (bus.state)
                ST_GR:   lamp1_d = LAMP_GRN;
                ST_YR:   lamp1_d = LAMP_YEL;
                ST_RG:   lamp2_d = LAMP_GRN;
                ST_RY:   lamp2_d = LAMP_YEL;
                default: ;
            endcase
        end
    end

    always_comb begin
        scan_cnt_d = scan_cnt_q + 20'd1;
        digit_d    = digit_q;
        if (scan_cnt_q >= SCAN_LAST) begin
            scan_cnt_d = '0;
            digit_d    = digit_q + 2'd1;
        end
    end

    always_comb begin
        an_sel   = 4'b1110;
        nib      = disp1_q.units;
        tens_sel = 1'b0;
        unique case (digit_q)
            2'd0: begin
                an_sel = 4'b1110;
                nib    = disp1_q.units;
            end
            2'd1: begin
                an_sel   = 4'b1101;
                nib      = disp1_q.tens;
                tens_sel = 1'b1;
            end
            2'd2: begin
                an_sel = 4'b1011;
                nib    = disp2_q.units;
            end
            2'd3: begin
                an_sel   = 4'b0111;
                nib      = disp2_q.tens;
                tens_sel = 1'b1;
            end
            default: ;
        endcase
        an_d  = 4'b1111;
        seg_d = '0;
        if (bus.enable) begin
            an_d = an_sel;
            // Leading zero on a tens digit stays selected but dark.
            if (!(tens_sel && nib == 4'd0)) seg_d = seg_encode(nib);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conv_q     <= ConvIdle;
            disp1_q    <= '0;
            disp2_q    <= '0;
            scan_cnt_q <= '0;
            digit_q    <= '0;
            lamp1_q    <= LAMP_RED;
            lamp2_q    <= LAMP_RED;
            an_q       <= 4'b1111;
            seg_q      <= '0;
        end else begin
            conv_q     <= conv_d;
            disp1_q    <= disp1_d;
            disp2_q    <= disp2_d;
            scan_cnt_q <= scan_cnt_d;
            digit_q    <= digit_d;
            lamp1_q    <= lamp1_d;
            lamp2_q    <= lamp2_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign bus.lamp1 = lamp1_q;
    assign bus.lamp2 = lamp2_q;
    assign bus.an    = an_q;
    assign bus.seg   = seg_q;

endmodule

// File: tb/tb_traffic_display.sv
// Self-checking bench for traffic_display: cycle-level reference model plus directed
// scenarios with hand-computed lamp and segment values.
module tb_traffic_display;

    localparam int unsigned SCAN_DIV = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    traffic_display_if bus ();

    traffic_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] SEGS [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Model: k counts edges since reset, n counts consecutive enabled edges.
    int         k = 0, n = 0, dig = 0;
    int         d1 = 0, d2 = 0, s1 = 0, s2 = 0;
    logic [2:0] e_lamp1 = 3'b100, e_lamp2 = 3'b100;
    logic [3:0] e_an = 4'b1111;
    logic [6:0] e_seg = 7'h00;
    bit         snap_evt = 1'b0;

    function automatic int sat99(input int t);
        return (t > 99) ? 99 : t;
    endfunction

    function automatic logic [6:0] digit_seg(input int v, input bit tens);
        if (tens && v == 0) return 7'h00;
        return SEGS[v];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_digit(input logic [3:0] an_v, input logic [6:0] seg_v,
                                input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (bus.an == an_v) begin
                seen = 1'b1;
                check(name, int'(bus.seg), int'(seg_v));
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: an=%b never selected, got an=%b", name, an_v, bus.an);
        end
    endtask

    task automatic wait_snap(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = snap_evt;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: got no snapshot, expected one within 20 cycles", name);
        end
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            k = 0; n = 0; d1 = 0; d2 = 0; s1 = 0; s2 = 0;
            e_lamp1 = 3'b100; e_lamp2 = 3'b100; e_an = 4'b1111; e_seg = 7'h00;
            snap_evt = 1'b0;
        end else begin
            dig = (k / SCAN_DIV) % 4;
            e_lamp1 = 3'b100;
            e_lamp2 = 3'b100;
            e_an    = 4'b1111;
            e_seg   = 7'h00;
            if (bus.enable) begin
                case (dig)
                    0: begin e_an = 4'b1110; e_seg = digit_seg(d1 % 10, 1'b0); end
                    1: begin e_an = 4'b1101; e_seg = digit_seg(d1 / 10, 1'b1); end
                    2: begin e_an = 4'b1011; e_seg = digit_seg(d2 % 10, 1'b0); end
                    default: begin e_an = 4'b0111; e_seg = digit_seg(d2 / 10, 1'b1); end
                endcase
                case (bus.state)
                    3'd3: e_lamp1 = 3'b001;
                    3'd4: e_lamp1 = 3'b010;
                    3'd5: e_lamp2 = 3'b001;
                    3'd6: e_lamp2 = 3'b010;
                    default: ;
                endcase
            end
            k++;
            n = bus.enable ? n + 1 : 0;
            snap_evt = 1'b0;
            if (!bus.enable) begin
                d1 = 0;
                d2 = 0;
            end else begin
                if (n >= 10 && (n - 10) % 9 == 0) begin
                    d1 = s1;
                    d2 = s2;
                end
                if (n >= 2 && (n - 2) % 9 == 0) begin
                    s1 = sat99(int'(bus.timeLane1));
                    s2 = sat99(int'(bus.timeLane2));
                    snap_evt = 1'b1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("model lamp1", int'(bus.lamp1), int'(e_lamp1));
        check("model lamp2", int'(bus.lamp2), int'(e_lamp2));
        check("model an", int'(bus.an), int'(e_an));
        check("model seg", int'(bus.seg), int'(e_seg));
    end

    localparam logic [2:0] STEP_ST [6] = '{3'd4, 3'd5, 3'd6, 3'd0, 3'd7, 3'd3};
    localparam logic [2:0] STEP_L1 [6] = '{3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001};
    localparam logic [2:0] STEP_L2 [6] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100};

    initial begin
        bus.enable    = 1'b1;
        bus.state     = 3'd3;
        bus.timeLane1 = 7'd25;
        bus.timeLane2 = 7'd30;
        repeat (2) @(negedge clk);
        check("reset an", int'(bus.an), 'hF);
        check("reset seg", int'(bus.seg), 0);
        rst = 1'b0;

        @(negedge clk);
        check("t1 lamp1", int'(bus.lamp1), 'b001);
        check("t1 lamp2", int'(bus.lamp2), 'b100);
        repeat (10) @(negedge clk);
        expect_digit(4'b1110, 7'h6D, "t1 lane1 units");
        expect_digit(4'b1101, 7'h5B, "t1 lane1 tens");
        expect_digit(4'b1011, 7'h3F, "t1 lane2 units");
        expect_digit(4'b0111, 7'h4F, "t1 lane2 tens");

        for (int i = 0; i < 6; i++) begin
            bus.state = STEP_ST[i];
            @(negedge clk);
            check($sformatf("t2 lamp1 st%0d", STEP_ST[i]), int'(bus.lamp1), int'(STEP_L1[i]));
            check($sformatf("t2 lamp2 st%0d", STEP_ST[i]), int'(bus.lamp2), int'(STEP_L2[i]));
        end

        bus.timeLane1 = 7'd7;
        bus.timeLane2 = 7'd120;
        repeat (20) @(negedge clk);
        expect_digit(4'b1101, 7'h00, "t3 lane1 tens blank");
        expect_digit(4'b1110, 7'h07, "t3 lane1 units");
        expect_digit(4'b1011, 7'h6F, "t3 lane2 units sat");
        expect_digit(4'b0111, 7'h6F, "t3 lane2 tens sat");

        bus.timeLane1 = 7'd25;
        bus.timeLane2 = 7'd30;
        repeat (20) @(negedge clk);
        wait_snap("t4 snapshot");
        repeat (2) @(negedge clk);
        bus.timeLane1 = 7'd42;
        repeat (7) @(negedge clk);
        expect_digit(4'b1101, 7'h5B, "t4 old tens kept");
        wait_snap("t4 next snapshot");
        repeat (9) @(negedge clk);
        expect_digit(4'b1101, 7'h66, "t4 new tens");

        wait_snap("t5 snapshot");
        bus.enable = 1'b0;
        @(negedge clk);
        check("t5 an off", int'(bus.an), 'hF);
        check("t5 seg off", int'(bus.seg), 0);
        check("t5 lamp1", int'(bus.lamp1), 'b100);
        check("t5 lamp2", int'(bus.lamp2), 'b100);
        bus.timeLane1 = 7'd42;
        bus.enable    = 1'b1;
        expect_digit(4'b1110, 7'h3F, "t5 cleared units");
        wait_snap("t5 resnapshot");
        repeat (9) @(negedge clk);
        expect_digit(4'b1101, 7'h66, "t5 tens 4");
        expect_digit(4'b1110, 7'h5B, "t5 units 2");

        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6 async lamp1", int'(bus.lamp1), 'b100);
        check("t6 async lamp2", int'(bus.lamp2), 'b100);
        check("t6 async an", int'(bus.an), 'hF);
        check("t6 async seg", int'(bus.seg), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_display.md
Name: traffic_display

Overview:
Downstream consumer of the auto-mode sequencer. Decodes the sequencer's `state` into per-lane lamp drives. Converts the two 7-bit countdowns into BCD with a sequential shift-add converter. Drives a 4-digit time-multiplexed 7-segment display: two digits per lane.

Parameters:
SCAN_DIV, 50000, clk cycles each digit stays selected (legal range 1..2^20).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  auto mode active; same signal that drives the sequencer
state  input  3  sequencer state: GR=3, YR=4, RG=5, RY=6
timeLane1  input  7  lane-1 remaining seconds, unsigned
timeLane2  input  7  lane-2 remaining seconds, unsigned
lamp1  output  3  lane-1 lamps {red,yellow,green}, active-high
lamp2  output  3  lane-2 lamps {red,yellow,green}, active-high
seg  output  7  segments {g,f,e,d,c,b,a}, active-high
an  output  4  digit select, active-low one-hot

Behaviour:
- Single clock domain.
- reset (async, active-high) forces:
  - lamp1=lamp2=3'b100
  - seg=0, an=4'b1111
  - scan counter=0, digit index=0
  - all BCD/display registers=0, converter FSM=IDLE
- Lamp decode is registered, with 1-cycle latency from state/enable:
  - GR: lamp1=001, lamp2=100
  - YR: lamp1=010, lamp2=100
  - RG: lamp1=100, lamp2=001
  - RY: lamp1=100, lamp2=010
  - Any other code, or enable=0: both lamps 100 (fail-safe all-red).
- Converter FSM has states IDLE, LOAD, SHIFT, DONE:
  - IDLE -> LOAD when enable=1.
  - LOAD: snapshot timeLane1/2 into working registers. Any value >99 is replaced by 99 (saturation).
  - SHIFT: 7 cycles of double-dabble on both lanes in parallel. Add 3 to any BCD nibble >=5 before each shift.
  - DONE: copy both 2-digit results into display registers atomically (all four nibbles in the same cycle), then go to LOAD.
  - Latency from snapshot cycle to display register update is 9 cycles. Steady state refreshes every 9 cycles.
  - enable=0 in any state: next state IDLE, display registers cleared, no partial result is ever published.
- Scan logic:
  - Counter runs 0..SCAN_DIV-1. On wrap, digit index advances 0->1->2->3->0.
  - SCAN_DIV=1 advances the index every cycle.
  - Digit mapping: 0=lane1 units (an=1110), 1=lane1 tens (1101), 2=lane2 units (1011), 3=lane2 tens (0111).
  - an and seg are registered together, so they change in the same cycle with no mismatch glitch.
  - Leading-zero blanking: when a tens nibble is 0, seg=0 for that digit while an stays asserted.
- Segment table: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. A nibble >9 (unreachable) gives seg=0.
- enable=0: an=1111, seg=0. The scan counter keeps running.
- Reset mid-conversion or mid-scan: immediate return to the reset values above. After release, the first published value appears 10 cycles after enable is seen high (1 IDLE->LOAD cycle + 9).
- Input changes during SHIFT are ignored until the next LOAD.

Decomposition:
- Shared package traffic_pkg holds:
  - state encodings GR/YR/RG/RY
  - lamp constants LAMP_RED=3'b100, LAMP_YEL=3'b010, LAMP_GRN=3'b001
  - the 10-entry segment table
  - the saturation constant 99
- Sub-module bin2bcd_seq: 7-bit in, two BCD nibbles out, with start/done handshake and 9-cycle latency. Instantiated once per lane, both started by the same LOAD strobe. The top level holds the lamp decoder, scan counter and output registers.

Test Plan:
1. Reset release with enable=1, state=3, timeLane1=25, timeLane2=30, SCAN_DIV=2 -> lamp1=001, lamp2=100 after 1 clk; after 10 clk digits read 5,2,0,3. The units digit of lane 1 shows an=1110 with seg=6D, and the tens digit of lane 2 shows an=0111 with seg=4F.
2. Step state 3->4->5->6 -> lamp pairs 010/100, 100/001, 100/010 one cycle after each change. state=0 or 7 -> both 100.
3. timeLane1=7, timeLane2=120 -> lane-1 tens digit has an asserted with seg=00, units seg=07. Lane 2 shows 99 (seg=6F on both digits).
4. Change timeLane1 from 25 to 42 during the 3rd SHIFT cycle -> display still shows 25 at that DONE; 42 appears at the following DONE, 9 cycles later.
5. Drop enable during SHIFT -> next clk an=1111, seg=0, lamps 100/100, display registers 0. Re-raise with timeLane1=42 -> 42 shown 10 clk later.
6. Assert reset asynchronously between clock edges mid-scan -> outputs reach their reset values before the next edge; scan counter and digit index restart at 0.
